h80_clock_ctrl: RTL

//  Run/step clock controller for the h80 CPU system. Debounces N raw push-buttons and

---
 rtl/h80_clock_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/h80_clock_ctrl.sv
// h80_clock_ctrl: button debounce, short/long press classification and run/step CPU clock enable
module h80_clock_ctrl #(
    parameter int NUM_BUTTONS     = 2,
    parameter int TICK_DIV        = 65536,
    parameter int DEBOUNCE_TICKS  = 41,
    parameter int LONGPRESS_TICKS = 824,
    parameter int RATE_BITS       = 5,
    parameter bit AUTORUN_INIT    = 1'b1
) (
    input  logic                   i_sysclk,
    input  logic                   i_reset,
    input  logic [NUM_BUTTONS-1:0] i_btn,
    input  logic [RATE_BITS-1:0]   i_rate_sel,
    input  logic                   i_halt_req,
    output logic [NUM_BUTTONS-1:0] o_btn_level,
    output logic [NUM_BUTTONS-1:0] o_btn_short,
    output logic [NUM_BUTTONS-1:0] o_btn_long,
    output logic                   o_autorun,
    output logic                   o_cpu_ce,
    output logic [31:0]            o_ce_count
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONGPRESS_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONGPRESS_TICKS);

    logic [PW-1:0]          r_presc;
    logic                   w_tick;
    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic                   r_autorun;
    logic                   r_cpu_ce;
    logic [31:0]            r_rate;
    logic [31:0]            r_ce_count;
    logic [31:0]            w_sel;
    logic [31:0]            w_mask;
    logic                   w_rate_hit;

    assign w_tick = (r_presc == PRESC_LAST);

    // Free-running prescaler producing the one-cycle debounce sample tick
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) r_presc <= '0;
        else         r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
            logic [DW-1:0] r_dcnt;
            logic [HW-1:0] r_hold;
            logic          r_level;
            logic          r_level_d;
            logic          r_at_max;
            logic          r_short;
            logic          r_long;
            logic          w_differ;
            logic          w_flip;
            logic          w_at_max;

            assign w_differ = r_sync2[g] ^ r_level;
            assign w_flip   = w_tick & w_differ & (r_dcnt == DEB_LAST);
            assign w_at_max = (r_hold == HOLD_MAX);

            // Debounce: the level flips on the DEBOUNCE_TICKS-th consecutive disagreeing tick
            always_ff @(posedge i_sysclk or posedge i_reset) begin
                if (i_reset) begin
                    r_dcnt  <= '0;
                    r_level <= 1'b0;
                end else if (w_tick) begin
                    r_dcnt  <= (!w_differ || w_flip) ? '0 : r_dcnt + DW'(1);
                    r_level <= r_level ^ w_flip;
                end
            end

            // Saturating hold counter; it still holds the press length in the cycle after release
            always_ff @(posedge i_sysclk or posedge i_reset) begin
                if (i_reset) begin
                    r_hold    <= '0;
                    r_at_max  <= 1'b0;
                    r_level_d <= 1'b0;
                    r_short   <= 1'b0;
                    r_long    <= 1'b0;
                end else begin
                    r_hold    <= !r_level ? '0 : (w_tick && !w_at_max) ? r_hold + HW'(1) : r_hold;
                    r_at_max  <= w_at_max;
                    r_long    <= w_at_max & ~r_at_max;
                    r_level_d <= r_level;
                    r_short   <= r_level_d & ~r_level & ~w_at_max;
                end
            end

            assign o_btn_level[g] = r_level;
            assign o_btn_short[g] = r_short;
            assign o_btn_long[g]  = r_long;
        end
    endgenerate

    assign w_sel      = 32'(i_rate_sel);
    assign w_mask     = (w_sel > 32'd31) ? 32'h7FFF_FFFF : ((32'd1 << w_sel[4:0]) - 32'd1);
    assign w_rate_hit = ((r_rate & w_mask) == w_mask);

    // Run control: autorun toggle with halt priority, rate counter, clock enable and its counter
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_autorun  <= AUTORUN_INIT;
            r_rate     <= '0;
            r_cpu_ce   <= 1'b0;
            r_ce_count <= '0;
        end else begin
            r_autorun  <= i_halt_req ? 1'b0 : r_autorun ^ o_btn_long[0];
            r_rate     <= r_autorun ? r_rate + 32'd1 : 32'd0;
            r_cpu_ce   <= ~i_halt_req & (r_autorun ? w_rate_hit : o_btn_short[0]);
            r_ce_count <= r_ce_count + 32'(r_cpu_ce);
        end
    end

    assign o_autorun  = r_autorun;
    assign o_cpu_ce   = r_cpu_ce;
    assign o_ce_count = r_ce_count;
endmodule
